// File: rtl/exp_series_engine.sv
// Sequential e^x evaluator: 1 + sum x^i/i!, with each term built recursively
// as term * x * (1/i). The 1/i coefficient comes from an external ROM indexed by ptr.
module exp_series_engine #(
    parameter int N_TERMS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  x,
    input  logic [7:0]  coeff,
    output logic [4:0]  ptr,
    output logic        busy,
    output logic        done,
    output logic [17:0] result
);

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        MULX,
        MULC,
        ACC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] xr;
    logic [15:0]       term;
    logic [17:0]       acc;
    logic [4:0]        i;
    logic [17:0]       acc_sum;

    // Q2.14 * Q1.7 -> Q3.21; dropping 7 LSBs truncates back to Q2.14.
    function automatic logic [15:0] mul_trunc(input logic [15:0] a,
                                              input logic [COEF_W-1:0] b);
        logic [23:0] prod;
        prod = {8'd0, a} * {16'd0, b};
        return 16'(prod >> 7);
    endfunction

    assign acc_sum = acc + {2'b00, term};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = MULX;
                end
            end
            MULX: state_next = MULC;
            MULC: state_next = ACC;
            ACC: begin
                if (i == 5'(N_TERMS)) begin
                    state_next = DONE;
                end else begin
                    state_next = MULX;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xr     <= '0;
            term   <= '0;
            acc    <= '0;
            i      <= 5'd1;
            ptr    <= 5'd1;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xr   <= x;
                        term <= 16'h4000;
                        acc  <= 18'h04000;
                        i    <= 5'd1;
                        ptr  <= 5'd1;
                    end
                end
                MULX: term <= mul_trunc(term, xr);
                // ptr has held i since the preceding state, so coeff is already 1/i here.
                MULC: term <= mul_trunc(term, coeff);
                ACC: begin
                    acc <= acc_sum;
                    if (i == 5'(N_TERMS)) begin
                        result <= acc_sum;
                    end else begin
                        i   <= i + 5'd1;
                        ptr <= i + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/exp_series_engine.md
Name: exp_series_engine

Overview:
- Sequential datapath/controller that evaluates e^x by Taylor series: 1 + sum over i=1..N_TERMS of x^i/i!.
- Sits directly upstream of the reciprocal ROM. It drives the ROM index and consumes the ROM's 1/i coefficient (Q1.7, combinational) on every term.
- Each term is built recursively: term_i = term_(i-1) * x * (1/i).

Parameters:
- N_TERMS, 8, number of series terms after the constant 1; legal range 1..16.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x  input  8  operand, unsigned Q1.7 (0 to 1.9921875).
- coeff  input  8  ROM output 1/ptr, unsigned Q1.7.
- ptr  output  5  ROM index, registered, 1..16.
- busy  output  1  high in MULX, MULC, ACC and DONE.
- done  output  1  high for exactly one cycle, in DONE.
- result  output  18  e^x, unsigned Q4.14; held until the next completion.

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs, legal mid-operation):
  - state=IDLE, ptr=1, busy=0, done=0, result=0.
  - internal registers: term=0, acc=0, i=1, xr=0.
- Internal registers: xr[7:0] (latched x), term[15:0] Q2.14, acc[17:0] Q4.14, i[4:0].
- IDLE:
  - on start=1: xr<=x, term<=16'h4000 (1.0), acc<=18'h04000 (1.0), i<=1, ptr<=1, go to MULX.
  - otherwise stay in IDLE.
- MULX: term <= (term*xr)[22:7]. Full 24-bit product; truncate (no rounding); keep 16 LSBs after the shift. Go to MULC.
- MULC: term <= (term*coeff)[22:7], same truncation rule. coeff is sampled this cycle and corresponds to ptr==i, which has been stable since the prior state. Go to ACC.
- ACC: acc <= acc + term (zero-extended, 18-bit add).
  - if i==N_TERMS: result <= acc+term, go to DONE.
  - else: i<=i+1, ptr<=i+1, go to MULX.
- DONE: done=1, busy=1. Next edge: go to IDLE, done=0.
- Latency:
  - Start sampled at edge E0.
  - DONE is entered after edge E0+3*N_TERMS; done is high in the cycle following that edge.
  - Total start-to-done = 3*N_TERMS+1 cycles.
  - Next start is accepted in IDLE, i.e. 3*N_TERMS+2 cycles after E0 at the earliest.
- start while busy (MULX/MULC/ACC/DONE): ignored. x changes while busy: ignored (xr latched).
- Width rules:
  - term < 2.0 for all legal x and i≥1 (x^i/i! < 2 for x<2), so Q2.14 never overflows.
  - acc < e^2 < 8, so Q4.14 never overflows.
  - No saturation logic is required.
- ptr: holds its last value in IDLE/DONE; returns to 1 only on reset or start.
- result: changes only on the final ACC edge or on reset.

Test Plan:
- Reset: rst=1 for 2 cycles, then idle -> ptr=1, busy=0, done=0, result=0; start held low -> no change.
- x=8'h00, N_TERMS=8, ROM model attached -> done at cycle 25 after start edge; result=18'h04000 (1.0); ptr steps 1..8.
- x=8'h80 (1.0), N_TERMS=2, coeff 1->8'h80, 2->8'h40:
  - term1=16'h4000, acc=18'h08000; term2=16'h2000.
  - result=18'h0A000 (2.5); done high exactly 1 cycle, 7 cycles after start edge.
- x=8'hFF, N_TERMS=16, full ROM model -> result bit-exact vs. golden model of the same truncation arithmetic; result < 18'h20000; ptr visits 1..16 in order, three cycles each.
- start pulsed again mid-computation with a different x -> ignored; result equals the first operand's value; busy stays high until DONE exits.
- rst asserted during MULC of term 3 -> next cycle IDLE, all outputs at reset values. A fresh start with x=8'h80, N_TERMS=2 -> result 18'h0A000.
